// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - sequential instruction prefetcher with a small FIFO and redirect flush
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        inst_ready_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic        full;
  logic        ack_req;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;

  assign full            = (count_q == DEPTH_C);
  assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
  assign ack_req         = (state_q == REQ) && mem_ack_i;
  // A redirect flushes everything, so it suppresses both the push and the pop of its cycle.
  assign push            = ack_req && !redirect_i && !full;
  assign pop             = inst_valid_o && inst_ready_i && !redirect_i;

  always_comb begin
    count_d = count_q;
    if (redirect_i) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    mem_req_o   = 1'b0;
    mem_addr_o  = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_target;
          if (start_i) state_d = REQ;
        end else if (start_i && !full) begin
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (redirect_i) begin
          fetch_pc_d = redirect_target;
          if (mem_ack_i) begin
            state_d = start_i ? REQ : IDLE;
          end else begin
            // The old request must still complete on the bus; remember its address.
            drop_addr_d = fetch_pc_q;
            state_d     = DROP;
          end
        end else if (mem_ack_i) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (start_i && (count_d < DEPTH_C)) ? REQ : IDLE;
        end
      end
      DROP: begin
        mem_req_o  = 1'b1;
        mem_addr_o = drop_addr_q;
        if (redirect_i) fetch_pc_d = redirect_target;
        if (mem_ack_i) state_d = start_i ? REQ : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      if (redirect_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      inst_mem[wr_ptr_q] <= mem_data_i;
    end
  end

  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? inst_mem[rd_ptr_q] : 32'd0;
  assign pc_o         = inst_valid_o ? pc_mem[rd_ptr_q]   : 32'd0;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - scoreboard bench for inst_prefetch_queue with a latency-randomized memory
module tb_inst_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = 32'd0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready_i = 1'b0;

  inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_ready_i (inst_ready_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Scoreboard: after a redirect (or reset) the core must see target, target+4, ... in order.
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_next;

  task automatic sb_redirect(input logic [31:0] t);
    exp_pc_q.delete();
    exp_next = t & 32'hFFFF_FFFC;
    repeat (8) begin
      exp_pc_q.push_back(exp_next);
      exp_next += 32'd4;
    end
  endtask

  // Memory model: random latency per request, address must hold while waiting.
  int          mem_min_lat = 0;
  int          mem_max_lat = 0;
  int          wait_cnt = 0;
  int          cur_lat = 0;
  bit          in_req = 1'b0;
  logic [31:0] held_addr = 32'd0;
  int          ack_cnt = 0;
  int          first_ack_cyc = -1;
  logic [31:0] ack_log[$];
  logic [31:0] req_log[$];

  always @(negedge clk) begin
    #1;
    if (!rst_i) begin
      mem_ack_i = 1'b0;
      in_req    = 1'b0;
      wait_cnt  = 0;
    end else if (mem_req_o) begin
      if (!in_req) begin
        in_req    = 1'b1;
        held_addr = mem_addr_o;
        wait_cnt  = 0;
        cur_lat   = $urandom_range(mem_max_lat, mem_min_lat);
        req_log.push_back(mem_addr_o);
      end else begin
        check("mem_addr_hold", mem_addr_o, held_addr);
      end
      if (wait_cnt >= cur_lat) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_word(held_addr);
        ack_log.push_back(held_addr);
        if (ack_cnt == 0) first_ack_cyc = cyc;
        ack_cnt++;
        in_req = 1'b0;
      end else begin
        mem_ack_i  = 1'b0;
        mem_data_i = $urandom;
        wait_cnt++;
      end
    end else begin
      mem_ack_i  = 1'b0;
      mem_data_i = $urandom;
      in_req     = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every accepted head word.
  int          hs_count = 0;
  int          first_valid_cyc = -1;
  logic [31:0] first_hs_pc = 32'hDEAD_BEEF;
  logic [31:0] exp_e;
  bit          prev_redirect = 1'b0;

  always @(negedge clk) begin
    #2;
    if (rst_i) begin
      if (prev_redirect) check("valid_after_redirect", {31'd0, inst_valid_o}, 32'd0);
      if (!inst_valid_o) begin
        check("empty_inst", inst_o, 32'd0);
        check("empty_pc", pc_o, 32'd0);
      end else if (first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
      end
      if (inst_valid_o && inst_ready_i && !redirect_i) begin
        if (exp_pc_q.size() == 0) begin
          exp_pc_q.push_back(exp_next);
          exp_next += 32'd4;
        end
        exp_e = exp_pc_q.pop_front();
        check("head_pc", pc_o, exp_e);
        check("head_inst", inst_o, mem_word(exp_e));
        if (hs_count == 0) first_hs_pc = pc_o;
        hs_count++;
      end
      prev_redirect = redirect_i;
    end else begin
      prev_redirect = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, {31'd0, mem_req_o}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr_o, RESET_PC);
    check({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd0);
    check({tag, "_inst"}, inst_o, 32'd0);
    check({tag, "_pc"}, pc_o, 32'd0);
  endtask

  task automatic clear_logs();
    ack_cnt = 0;
    ack_log.delete();
    req_log.delete();
    first_ack_cyc   = -1;
    first_valid_cyc = -1;
    hs_count        = 0;
    first_hs_pc     = 32'hDEAD_BEEF;
    sb_redirect(RESET_PC);
  endtask

  task automatic do_reset();
    rst_i         = 1'b0;
    start_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    inst_ready_i  = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    clear_logs();
    tick();
    rst_i = 1'b1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    sample();
    while (!mem_req_o && n < 50) begin
      sample();
      n++;
    end
    if (!mem_req_o) check("wait_req_timeout", 32'd0, 32'd1);
  endtask

  int h0;
  int n200;
  int nw;

  initial begin
    // Zero-wait streaming.
    mem_min_lat = 0; mem_max_lat = 0;
    do_reset();
    start_i = 1'b1; inst_ready_i = 1'b1;
    repeat (10) tick();
    h0 = hs_count;
    repeat (20) tick();
    check("b_throughput", hs_count - h0, 32'd20);
    if (ack_log.size() >= 3) begin
      check("b_addr0", ack_log[0], 32'h0);
      check("b_addr1", ack_log[1], 32'h4);
      check("b_addr2", ack_log[2], 32'h8);
    end else check("b_ack_count", ack_log.size(), 32'd3);
    check("b_valid_latency", first_valid_cyc - first_ack_cyc, 32'd1);

    // Back-pressure: fill exactly DEPTH, then one pop frees one slot.
    do_reset();
    start_i = 1'b1; inst_ready_i = 1'b0;
    repeat (15) tick();
    check("c_fill_acks", ack_cnt, DEPTH);
    check("c_req_low_full", {31'd0, mem_req_o}, 32'd0);
    check("c_no_pop", hs_count, 32'd0);
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    repeat (10) tick();
    check("c_one_pop", hs_count, 32'd1);
    check("c_refill_acks", ack_cnt, DEPTH + 1);
    if (ack_log.size() >= 5) check("c_refill_addr", ack_log[4], 32'h10);
    check("c_req_low_refull", {31'd0, mem_req_o}, 32'd0);

    // 3-cycle memory, redirect during the wait.
    mem_min_lat = 3; mem_max_lat = 3;
    do_reset();
    start_i = 1'b1; inst_ready_i = 1'b1;
    wait_req();
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h103; sb_redirect(32'h103);
    tick();
    redirect_i = 1'b0;
    repeat (30) tick();
    if (req_log.size() >= 2) begin
      check("d_req0", req_log[0], 32'h0);
      check("d_req1", req_log[1], 32'h100);
    end else check("d_req_count", req_log.size(), 32'd2);
    check("d_hs_seen", {31'd0, hs_count > 0}, 32'd1);
    check("d_first_pc", first_hs_pc, 32'h100);

    // Redirect coinciding with ack and pop, two entries queued.
    mem_min_lat = 0; mem_max_lat = 0;
    do_reset();
    start_i = 1'b1; inst_ready_i = 1'b0;
    nw = 0;
    sample();
    while (ack_cnt < 2 && nw < 20) begin
      sample();
      nw++;
    end
    check("e_two_acks", {31'd0, ack_cnt >= 2}, 32'd1);
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h400; inst_ready_i = 1'b1; sb_redirect(32'h400);
    #2;
    check("e_ack_same_cycle", {31'd0, mem_ack_i}, 32'd1);
    check("e_valid_same_cycle", {31'd0, inst_valid_o}, 32'd1);
    tick();
    redirect_i = 1'b0;
    #2;
    check("e_flushed", {31'd0, inst_valid_o}, 32'd0);
    check("e_req", {31'd0, mem_req_o}, 32'd1);
    check("e_req_addr", mem_addr_o, 32'h400);
    repeat (10) tick();
    check("e_hs_seen", {31'd0, hs_count > 0}, 32'd1);
    check("e_first_pc", first_hs_pc, 32'h400);

    // Two redirects back to back, second one while dropping.
    mem_min_lat = 3; mem_max_lat = 3;
    do_reset();
    start_i = 1'b1; inst_ready_i = 1'b1;
    wait_req();
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h200; sb_redirect(32'h200);
    tick();
    redirect_pc_i = 32'h300; sb_redirect(32'h300);
    tick();
    redirect_i = 1'b0;
    repeat (40) tick();
    n200 = 0;
    foreach (req_log[i]) if (req_log[i] == 32'h200) n200++;
    check("f_no_200_req", n200, 32'd0);
    if (req_log.size() >= 2) check("f_req1", req_log[1], 32'h300);
    else check("f_req_count", req_log.size(), 32'd2);
    check("f_first_pc", first_hs_pc, 32'h300);

    // Random traffic against the scoreboard.
    mem_min_lat = 0; mem_max_lat = 3;
    do_reset();
    start_i = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      inst_ready_i  = ($urandom % 10) < 7;
      redirect_i    = ($urandom % 25) == 0;
      redirect_pc_i = $urandom;
      if (redirect_i) sb_redirect(redirect_pc_i);
      if (($urandom % 40) == 0) start_i = ~start_i;
    end
    tick();
    redirect_i = 1'b0; start_i = 1'b1; inst_ready_i = 1'b1;
    h0 = hs_count;
    repeat (30) tick();
    check("g_liveness", {31'd0, hs_count > h0}, 32'd1);

    // Asynchronous reset in the middle of a request.
    mem_min_lat = 3; mem_max_lat = 3;
    do_reset();
    start_i = 1'b1; inst_ready_i = 1'b1;
    wait_req();
    tick();
    rst_i = 1'b0;
    #1;
    check_reset_outputs("h_async");
    repeat (2) tick();
    clear_logs();
    rst_i = 1'b1;
    repeat (30) tick();
    if (req_log.size() >= 1) check("h_restart_addr", req_log[0], RESET_PC);
    else check("h_req_count", req_log.size(), 32'd1);
    check("h_hs_seen", {31'd0, hs_count > 0}, 32'd1);
    check("h_first_pc", first_hs_pc, RESET_PC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
